coords_stream: RTL

COORDS_STREAM -- requirements
Module: coords_stream

---
 rtl/coords_stream.sv | 118 +++++++++++
 1 files changed

// File: rtl/coords_stream.sv
// Streams pixel coordinates of a cfg_w x cfg_h frame, LANES coordinates per beat, with valid/ready flow control.
// Optional COORDS_STREAM_SERPENTINE_EN scans odd rows right-to-left.
module coords_stream #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int LANES  = 4,
  localparam int WB    = $clog2(WIDTH),
  localparam int HB    = $clog2(HEIGHT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WB:0]         cfg_w,
  input  logic [HB:0]         cfg_h,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*WB-1:0] x,
  output logic [LANES*HB-1:0] y,
  output logic                line_last,
  output logic                frame_last,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WB:0] LANES_W  = (WB+1)'(LANES);
  localparam logic [WB:0] WIDTH_W  = (WB+1)'(WIDTH);
  localparam logic [HB:0] HEIGHT_W = (HB+1)'(HEIGHT);

  state_t      state, state_nxt;
  logic [WB:0] base;
  logic [HB:0] row;
  logic [WB:0] cfg_w_q;
  logic [HB:0] cfg_h_q;
  logic        cfg_ok;
  logic        line_end;
  logic        row_end;
  logic [WB:0] pos;

  assign cfg_ok   = (cfg_w != '0) && (cfg_w <= WIDTH_W) && ((cfg_w % LANES_W) == '0) &&
                    (cfg_h != '0) && (cfg_h <= HEIGHT_W);
  assign line_end = (base + LANES_W) == cfg_w_q;
  assign row_end  = row == (cfg_h_q - (HB+1)'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && cfg_ok) state_nxt = RUN;
      RUN:     if (out_ready && line_end && row_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = (state == RUN);
    busy       = (state == RUN);
    line_last  = (state == RUN) && line_end;
    frame_last = (state == RUN) && line_end && row_end;
  end

  // base/row are left untouched on the final transfer so x/y keep showing the last beat in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base    <= '0;
      row     <= '0;
      cfg_w_q <= '0;
      cfg_h_q <= '0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (cfg_ok) begin
            cfg_w_q <= cfg_w;
            cfg_h_q <= cfg_h;
            base    <= '0;
            row     <= '0;
          end else begin
            cfg_err <= 1'b1;
          end
        end
      end else if (out_ready) begin
        if (frame_last) begin
          done <= 1'b1;
        end else if (line_end) begin
          base <= '0;
          row  <= row + (HB+1)'(1);
        end else begin
          base <= base + LANES_W;
        end
      end
    end
  end

  always_comb begin
    x   = '0;
    y   = '0;
    pos = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pos = base + (WB+1)'(i);
`ifdef COORDS_STREAM_SERPENTINE_EN
      if (row[0]) pos = cfg_w_q - (WB+1)'(1) - pos;
`endif
      x[i*WB +: WB] = WB'(pos);
      y[i*HB +: HB] = HB'(row);
    end
  end

endmodule
